// File: rtl/btn_defs.sv
// -----------------------------------------------------------------------------
// btn_defs
//   Shared definitions for the push-button conditioning blocks: FSM state
//   encoding, default cycle constants for a 100 MHz clock, and the
//   repeat-acceleration constants with a helper that derives the shortened
//   repeat period.
// -----------------------------------------------------------------------------
package btn_defs;

   // Button FSM states
   typedef enum logic [1:0] {
      ST_RELEASED = 2'd0,
      ST_HELD     = 2'd1,
      ST_REPEAT   = 2'd2
   } state_t;

   // Default timing at 100 MHz
   localparam int DEF_DEBOUNCE_CYC = 1_000_000;   // 10 ms
   localparam int DEF_LONG_CYC     = 50_000_000;  // 500 ms
   localparam int DEF_REPEAT_CYC   = 10_000_000;  // 100 ms
   localparam int DEF_CNT_W        = 26;

   // Repeat acceleration: after ACCEL_AFTER repeats the period is divided by ACCEL_DIV
   localparam int ACCEL_AFTER = 8;
   localparam int ACCEL_DIV   = 4;

   // Accelerated repeat period, never below one cycle
   function automatic int accel_period(input int rep_cyc);
      int p;
      p = rep_cyc / ACCEL_DIV;
      if (p < 1) begin
         p = 1;
      end else begin
         p = p;
      end
      return p;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Two-flop synchroniser followed by a stability counter. The debounced level
//   only toggles after the synchronised input has differed from it for
//   DEBOUNCE_CYC consecutive cycles; any agreement restarts the count.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous reset, active low
//   btn        in   raw asynchronous button
//   btn_level  out  debounced level (registered)
// -----------------------------------------------------------------------------
module button_debouncer
   import btn_defs::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int CNT_W        = DEF_CNT_W
)(
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic btn_level
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic [CNT_W-1:0] deb_cnt_r;
   logic             level_r;

   // Synchroniser, stability counter and debounced level
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_r   <= 1'b0;
         sync2_r   <= 1'b0;
         deb_cnt_r <= CNT_ZERO;
         level_r   <= 1'b0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
         if (sync2_r == level_r) begin
            deb_cnt_r <= CNT_ZERO;
         end else if (deb_cnt_r == DEB_LAST) begin
            // Input has disagreed long enough: accept the new level
            level_r   <= ~level_r;
            deb_cnt_r <= CNT_ZERO;
         end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
         end
      end
   end

   assign btn_level = level_r;

endmodule

// File: rtl/button_repeat_conditioner.sv
// -----------------------------------------------------------------------------
// button_repeat_conditioner
//   Turns one raw bouncy push-button into clean single-cycle events: press,
//   release, and auto-repeat while held. A debouncer sub-module produces the
//   stable level; a three-state FSM (RELEASED / HELD / REPEAT) with hold and
//   repeat counters produces registered pulses.
//
//   Optional macro BTN_REPEAT_ACCEL_EN: after ACCEL_AFTER repeat pulses within
//   one hold the repeat period shrinks to REPEAT_CYC/ACCEL_DIV (minimum 1).
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous reset, active low
//   btn            in   raw asynchronous button, active high
//   btn_level      out  debounced level
//   btn_pedge      out  1-cycle pulse on accepted press and on every repeat
//   btn_nedge      out  1-cycle pulse on accepted release
//   short_release  out  1-cycle pulse with btn_nedge when released before first repeat
//   repeating      out  high while in REPEAT
// -----------------------------------------------------------------------------
module button_repeat_conditioner
   import btn_defs::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int LONG_CYC     = DEF_LONG_CYC,
   parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
   parameter int CNT_W        = DEF_CNT_W
)(
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic btn_level,
   output logic btn_pedge,
   output logic btn_nedge,
   output logic short_release,
   output logic repeating
);

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   logic             level_s;
   state_t           state_r, state_s;
   logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
   logic [CNT_W-1:0] rep_cnt_r, rep_cnt_s;
   logic [CNT_W-1:0] rep_last_s;
   logic             hold_done_s, rep_done_s;
   logic             pedge_s, nedge_s, short_s, repeating_s;
   logic             pedge_r, nedge_r, short_r, repeating_r;

   button_debouncer #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_debouncer (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .btn_level (level_s)
   );

   assign hold_done_s = (hold_cnt_r == LONG_LAST);
   assign rep_done_s  = (rep_cnt_r == rep_last_s);

`ifdef BTN_REPEAT_ACCEL_EN
   localparam logic [CNT_W-1:0] ACC_LAST    = CNT_W'(accel_period(REPEAT_CYC) - 1);
   localparam logic [3:0]       ACC_AFTER_C = 4'(ACCEL_AFTER);

   logic [3:0] acc_cnt_r, acc_cnt_s;

   // Repeat terminal count: shortened once enough repeats have fired
   always_comb begin
      if (acc_cnt_r >= ACC_AFTER_C) begin
         rep_last_s = ACC_LAST;
      end else begin
         rep_last_s = REP_LAST;
      end
   end

   // Repeat-pulse counter: cleared outside/entering REPEAT, saturating otherwise
   always_comb begin
      acc_cnt_s = acc_cnt_r;
      if (state_s != ST_REPEAT) begin
         acc_cnt_s = 4'd0;
      end else if (state_r != ST_REPEAT) begin
         acc_cnt_s = 4'd0;
      end else if (rep_done_s && (acc_cnt_r != 4'd15)) begin
         acc_cnt_s = acc_cnt_r + 4'd1;
      end else begin
         acc_cnt_s = acc_cnt_r;
      end
   end

   // Repeat-pulse counter register
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_cnt_r <= 4'd0;
      end else begin
         acc_cnt_r <= acc_cnt_s;
      end
   end
`else
   assign rep_last_s = REP_LAST;
`endif

   // State and counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= ST_RELEASED;
         hold_cnt_r <= CNT_ZERO;
         rep_cnt_r  <= CNT_ZERO;
      end else begin
         state_r    <= state_s;
         hold_cnt_r <= hold_cnt_s;
         rep_cnt_r  <= rep_cnt_s;
      end
   end

   // Next-state and counter logic; a release always takes priority over expiry
   always_comb begin
      state_s    = state_r;
      hold_cnt_s = hold_cnt_r;
      rep_cnt_s  = rep_cnt_r;
      case (state_r)
         ST_RELEASED: begin
            if (level_s) begin
               state_s    = ST_HELD;
               hold_cnt_s = CNT_ZERO;
            end else begin
               state_s = ST_RELEASED;
            end
         end
         ST_HELD: begin
            if (!level_s) begin
               state_s = ST_RELEASED;
            end else if (hold_done_s) begin
               // hold_cnt stays at its terminal value
               state_s   = ST_REPEAT;
               rep_cnt_s = CNT_ZERO;
            end else begin
               hold_cnt_s = hold_cnt_r + CNT_ONE;
            end
         end
         ST_REPEAT: begin
            if (!level_s) begin
               state_s = ST_RELEASED;
            end else if (rep_done_s) begin
               rep_cnt_s = CNT_ZERO;
            end else begin
               rep_cnt_s = rep_cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s    = ST_RELEASED;
            hold_cnt_s = CNT_ZERO;
            rep_cnt_s  = CNT_ZERO;
         end
      endcase
   end

   // Pulse decode for the coming cycle
   always_comb begin
      pedge_s     = 1'b0;
      nedge_s     = 1'b0;
      short_s     = 1'b0;
      repeating_s = (state_s == ST_REPEAT);
      case (state_r)
         ST_RELEASED: begin
            pedge_s = level_s;
         end
         ST_HELD: begin
            if (!level_s) begin
               nedge_s = 1'b1;
               short_s = 1'b1;
            end else begin
               pedge_s = hold_done_s;
            end
         end
         ST_REPEAT: begin
            if (!level_s) begin
               nedge_s = 1'b1;
            end else begin
               pedge_s = rep_done_s;
            end
         end
         default: begin
            pedge_s = 1'b0;
         end
      endcase
   end

   // Output pulse registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         pedge_r     <= 1'b0;
         nedge_r     <= 1'b0;
         short_r     <= 1'b0;
         repeating_r <= 1'b0;
      end else begin
         pedge_r     <= pedge_s;
         nedge_r     <= nedge_s;
         short_r     <= short_s;
         repeating_r <= repeating_s;
      end
   end

   assign btn_level     = level_s;
   assign btn_pedge     = pedge_r;
   assign btn_nedge     = nedge_r;
   assign short_release = short_r;
   assign repeating     = repeating_r;

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_repeat_conditioner
//   Directed scenarios with literal expectations plus a randomized phase, all
//   outputs compared every cycle against a behavioural model that works from
//   the raw-input history and the time elapsed since the press pulse.
// -----------------------------------------------------------------------------
module tb_button_repeat_conditioner;

   localparam int DEB   = 4;
   localparam int LONG  = 20;
   localparam int REP   = 5;
   localparam int CW    = 26;
   localparam int ACC_N = 8;

   logic clk = 1'b0;
   logic reset;
   logic btn;
   logic btn_level, btn_pedge, btn_nedge, short_release, repeating;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   button_repeat_conditioner #(
      .DEBOUNCE_CYC (DEB),
      .LONG_CYC     (LONG),
      .REPEAT_CYC   (REP),
      .CNT_W        (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn           (btn),
      .btn_level     (btn_level),
      .btn_pedge     (btn_pedge),
      .btn_nedge     (btn_nedge),
      .short_release (short_release),
      .repeating     (repeating)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   // hist[i] = raw btn seen at the i-th most recent posedge (0 = this one).
   // The level flips when the synchronised samples (two edges old) have all
   // disagreed with it for DEB consecutive edges.
   // age = edges since the press pulse (-1 when not pressed).
   bit hist [DEB+2];
   bit m_lvl   = 1'b0;
   int age     = -1;
   bit m_pedge = 1'b0, m_nedge = 1'b0, m_short = 1'b0, m_rep = 1'b0;

   function automatic bit rep_due(input int k);
`ifdef BTN_REPEAT_ACCEL_EN
      if (k > ACC_N * REP) return 1'b1;
`endif
      return (k % REP) == 0;
   endfunction

   always @(posedge clk) begin
      bit all_diff;
      if (!reset) begin
         for (int i = 0; i < DEB + 2; i++) hist[i] = 1'b0;
         m_lvl = 1'b0; age = -1;
         m_pedge = 1'b0; m_nedge = 1'b0; m_short = 1'b0; m_rep = 1'b0;
      end else begin
         m_pedge = 1'b0; m_nedge = 1'b0; m_short = 1'b0;
         if (m_lvl) begin
            if (age < 0) begin
               age = 0;
               m_pedge = 1'b1;
            end else begin
               age = age + 1;
               if (age == LONG) m_pedge = 1'b1;
               else if (age > LONG && rep_due(age - LONG)) m_pedge = 1'b1;
            end
            m_rep = (age >= LONG);
         end else begin
            if (age >= 0) begin
               m_nedge = 1'b1;
               m_short = (age + 1 <= LONG);
            end
            age = -1;
            m_rep = 1'b0;
         end
         for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = btn;
         all_diff = 1'b1;
         for (int i = 2; i < DEB + 2; i++) if (hist[i] == m_lvl) all_diff = 1'b0;
         if (all_diff) m_lvl = ~m_lvl;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      check("level",     int'(btn_level),     int'(m_lvl));
      check("pedge",     int'(btn_pedge),     int'(m_pedge));
      check("nedge",     int'(btn_nedge),     int'(m_nedge));
      check("short",     int'(short_release), int'(m_short));
      check("repeating", int'(repeating),     int'(m_rep));
   end

   // ---------------- event monitor for directed checks ----------------
   int pedge_q[$];
   int n_nedge = 0, n_short = 0, n_rep = 0, last_nedge = 0, rep_rise = 0;
   bit prev_rep = 1'b0;

   always @(negedge clk) begin
      if (btn_pedge) pedge_q.push_back(cyc);
      if (btn_nedge) begin n_nedge++; last_nedge = cyc; end
      if (short_release) n_short++;
      if (repeating) n_rep++;
      if (repeating && !prev_rep) rep_rise = cyc;
      prev_rep = repeating;
   end

   int t4_exp [9] = '{0, 20, 25, 30, 35, 40, 45, 50, 55};

   initial begin
      int base, sn, ss, sr;
      bit lv_seen;

      // 1: reset with button held, then debounce latency
      reset = 1'b0; btn = 1'b1;
      tick(3);
      check("t1_rst_level", int'(btn_level), 0);
      check("t1_rst_pedge", int'(btn_pedge), 0);
      check("t1_rst_rep",   int'(repeating), 0);
      reset = 1'b1;
      tick(5);
      check("t1_level_5", int'(btn_level), 0);
      tick(1);
      check("t1_level_6", int'(btn_level), 1);
      tick(1);
      check("t1_pedge", int'(btn_pedge), 1);
      btn = 1'b0;
      tick(25);

      // 2: 3-cycle bounce never accepted
      base = pedge_q.size(); lv_seen = 1'b0;
      btn = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(1); lv_seen |= btn_level; end
      btn = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(1); lv_seen |= btn_level; end
      check("t2_level", int'(lv_seen), 0);
      check("t2_pedge", pedge_q.size() - base, 0);

      // 3: short press
      base = pedge_q.size(); sn = n_nedge; ss = n_short; sr = n_rep;
      btn = 1'b1; tick(10); btn = 1'b0; tick(25);
      check("t3_pedges", pedge_q.size() - base, 1);
      check("t3_nedges", n_nedge - sn, 1);
      check("t3_short",  n_short - ss, 1);
      check("t3_rep",    n_rep - sr, 0);

      // 4: long hold with repeats
      base = pedge_q.size(); sn = n_nedge; ss = n_short;
      btn = 1'b1; tick(60); btn = 1'b0; tick(25);
      check("t4_pedges", pedge_q.size() - base, 9);
      if (pedge_q.size() - base == 9) begin
         for (int i = 0; i < 9; i++)
            check("t4_offset", pedge_q[base+i] - pedge_q[base], t4_exp[i]);
         check("t4_rep_rise", rep_rise - pedge_q[base], 20);
         check("t4_nedge_at", last_nedge - pedge_q[base], 60);
      end
      check("t4_nedges", n_nedge - sn, 1);
      check("t4_short",  n_short - ss, 0);

      // 5: release coincides with a repeat slot
      base = pedge_q.size(); sn = n_nedge;
      btn = 1'b1; tick(45); btn = 1'b0; tick(25);
      check("t5_pedges", pedge_q.size() - base, 6);
      check("t5_nedges", n_nedge - sn, 1);
      if (pedge_q.size() > base)
         check("t5_nedge_at", last_nedge - pedge_q[base], 45);

      // 6: 100-cycle hold
      base = pedge_q.size();
      btn = 1'b1; tick(100); btn = 1'b0; tick(25);
`ifdef BTN_REPEAT_ACCEL_EN
      check("t6_pedges", pedge_q.size() - base, 49);
      if (pedge_q.size() - base >= 11)
         check("t6_gap", pedge_q[base+10] - pedge_q[base+9], 1);
`else
      check("t6_pedges", pedge_q.size() - base, 17);
      if (pedge_q.size() - base >= 11)
         check("t6_gap", pedge_q[base+10] - pedge_q[base+9], 5);
`endif
      if (pedge_q.size() > base)
         check("t6_nedge_at", last_nedge - pedge_q[base], 100);

      // 7: reset during REPEAT
      btn = 1'b1; tick(30);
      check("t7_repeating", int'(repeating), 1);
      reset = 1'b0; tick(1);
      check("t7_rst_rep",   int'(repeating), 0);
      check("t7_rst_level", int'(btn_level), 0);
      check("t7_rst_nedge", int'(btn_nedge), 0);
      check("t7_rst_pedge", int'(btn_pedge), 0);
      sn = n_nedge;
      tick(2);
      btn = 1'b0; reset = 1'b1;
      tick(20);
      check("t7_no_nedge", n_nedge - sn, 0);

      // Randomized phase: bounces, holds of all lengths, occasional reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b0; tick($urandom_range(1, 3)); reset = 1'b1;
         end
         btn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
         else tick($urandom_range(4, 60));
      end

      btn = 1'b0;
      tick(30);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
